aud_i2s_tx: RTL and testbench

Parametrised stereo DAC serializer: the next-generation audio playback path toward the WM8731. It accepts processed stereo frames from the DSP over a valid/ready handshake and buffers them in a small frame FIFO. It serializes each sample MSB-first on `o_aud_dacdat`, synchronised to the codec-supplied `i_bclk`/`i_daclrck`. It generalises sample width, buffer depth and framing mode, and adds mono duplication and underrun reporting.

---
 rtl/aud_pkg.sv | 21 ++
 rtl/aud_frame_fifo.sv | 70 +++++++
 rtl/aud_i2s_tx.sv | 163 ++++++++++++++++
 tb/tb_aud_i2s_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types for the I2S / left-justified DAC serializer: framing mode, word FSM states
// and the width helper for the per-word bit counter.
package aud_pkg;

  typedef enum logic {
    AUD_I2S = 1'b0,
    AUD_LJ  = 1'b1
  } aud_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } tx_state_e;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/aud_frame_fifo.sv
// Stereo frame FIFO: registered full/empty/level, read data valid combinationally at pop.
// Push visible in level one cycle later; push refused while full, even alongside a pop.
module aud_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = i_push & ~full_q;
  assign pop_ok  = i_pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_level = level_q;

endmodule

// File: rtl/aud_i2s_tx.sv
// Stereo DAC serializer toward the WM8731: frames buffered in a FIFO, shifted out MSB-first per LRCK slot.
// LJ MSB at the edge cycle, I2S one bclk later; o_ready drops when the FIFO is full.
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     i_bclk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_daclrck,
  input  logic                     i_mode,
  input  logic                     i_mono,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_dac_l,
  input  logic [DATA_W-1:0]        i_dac_r,
  output logic                     o_aud_dacdat,
  output logic                     o_underrun,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int CNT_W = bit_cnt_w(DATA_W);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  shl_q, shl_d;
  logic [DATA_W-1:0]  shr_q, shr_d;
  logic               dat_q, dat_d;
  logic               und_q, und_d;
  logic               act_q, act_d;
  logic               lrck_q;

  logic               left_edge, right_edge;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic               start;
  logic [DATA_W-1:0]  word;
  aud_mode_e          mode;

  assign mode       = aud_mode_e'(i_mode);
  assign left_edge  = lrck_q & ~i_daclrck;
  assign right_edge = ~lrck_q & i_daclrck;

  aud_frame_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_bclk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_wdata ({i_dac_l, i_dac_r}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    shl_d    = shl_q;
    shr_d    = shr_q;
    dat_d    = dat_q;
    act_d    = act_q;
    und_d    = 1'b0;
    fifo_pop = 1'b0;
    start    = 1'b0;
    word     = '0;

    if (!i_en) begin
      state_d = S_IDLE;
      dat_d   = 1'b0;
      act_d   = 1'b0;
    end else begin
      if (left_edge) begin
        start = 1'b1;
        act_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shl_d    = fifo_rdata[2*DATA_W-1:DATA_W];
          shr_d    = fifo_rdata[DATA_W-1:0];
          word     = fifo_rdata[2*DATA_W-1:DATA_W];
        end else begin
          und_d = 1'b1;
          shl_d = '0;
          shr_d = '0;
        end
      end else if (right_edge && act_q) begin
        start = 1'b1;
        word  = i_mono ? shl_q : shr_q;
      end

      // A slot edge always restarts the word, whatever the current state.
      if (start) begin
        if (mode == AUD_LJ) begin
          dat_d   = word[DATA_W-1];
          shift_d = word << 1;
          cnt_d   = CNT_W'(DATA_W-1);
          state_d = S_SHIFT;
        end else begin
          dat_d   = 1'b0;
          shift_d = word;
          state_d = S_DELAY;
        end
      end else begin
        case (state_q)
          S_DELAY: begin
            dat_d   = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = CNT_W'(DATA_W-1);
            state_d = S_SHIFT;
          end
          S_SHIFT: begin
            if (cnt_q == '0) begin
              dat_d   = 1'b0;
              state_d = S_PAD;
            end else begin
              dat_d   = shift_q[DATA_W-1];
              shift_d = shift_q << 1;
              cnt_d   = cnt_q - CNT_W'(1);
            end
          end
          default: dat_d = 1'b0;
        endcase
      end
    end
  end

  // lrck_q tracks the live pin during reset so release never looks like an edge.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      shl_q   <= '0;
      shr_q   <= '0;
      dat_q   <= 1'b0;
      und_q   <= 1'b0;
      act_q   <= 1'b0;
      lrck_q  <= i_daclrck;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      dat_q   <= dat_d;
      und_q   <= und_d;
      act_q   <= act_d;
      lrck_q  <= i_daclrck;
    end
  end

  assign o_ready      = ~fifo_full;
  assign o_aud_dacdat = dat_q;
  assign o_underrun   = und_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed scoreboard bench for aud_i2s_tx: stimulus queues per-cycle expectations,
// a negedge monitor compares serial data, underrun, level and ready against them.
module tb_aud_i2s_tx;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          i_bclk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic          i_daclrck;
  logic          i_mode;
  logic          i_mono;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_dac_l;
  logic [DW-1:0] i_dac_r;
  logic          o_aud_dacdat;
  logic          o_underrun;
  logic [2:0]    o_level;

  aud_i2s_tx #(.DATA_W(DW), .DEPTH(DP)) dut (
    .i_bclk       (i_bclk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_daclrck    (i_daclrck),
    .i_mode       (i_mode),
    .i_mono       (i_mono),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_dac_l      (i_dac_l),
    .i_dac_r      (i_dac_r),
    .o_aud_dacdat (o_aud_dacdat),
    .o_underrun   (o_underrun),
    .o_level      (o_level)
  );

  always #5 i_bclk = ~i_bclk;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge i_bclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  // Monitor: compares every queued expectation due at the current cycle.
  always @(negedge i_bclk) begin
    int i;
    int act;
    string nm;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc <= cyc) begin
        case (exp_q[i].kind)
          0:       begin act = int'(o_aud_dacdat); nm = "dacdat";   end
          1:       begin act = int'(o_underrun);   nm = "underrun"; end
          2:       begin act = int'(o_level);      nm = "level";    end
          default: begin act = int'(o_ready);      nm = "ready";    end
        endcase
        if (exp_q[i].cyc < cyc) nm = {nm, "_late"};
        chk(nm, act, exp_q[i].val);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge i_bclk);
    #1;
  endtask

  task automatic expect_at(input int c, input int k, input int v);
    exp_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // One LRCK half-period of len bclks; und/lvl < 0 means "not checked".
  task automatic slot(input bit lr, input int len, input logic [DW-1:0] word,
                      input bit i2s, input int und, input int lvl);
    int k;
    int b;
    int v;
    i_daclrck = lr;
    i_mode    = i2s ? 1'b0 : 1'b1;
    k = cyc + 1;
    for (int j = 0; j < len; j++) begin
      b = i2s ? j - 1 : j;
      v = (b >= 0 && b < DW) ? int'(word[DW-1-b]) : 0;
      expect_at(k + j, 0, v);
    end
    if (und >= 0) begin
      expect_at(k, 1, und);
      expect_at(k + 1, 1, 0);
    end
    if (lvl >= 0) expect_at(k, 2, lvl);
    repeat (len) step();
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lvl);
    i_valid = 1'b1;
    i_dac_l = l;
    i_dac_r = r;
    expect_at(cyc + 1, 2, lvl);
    step();
    i_valid = 1'b0;
  endtask

  logic [DW-1:0] fl [5];
  logic [DW-1:0] fr [5];

  initial begin
    fl[0] = 16'h1234; fr[0] = 16'hFEDC;
    fl[1] = 16'h8000; fr[1] = 16'h0001;
    fl[2] = 16'h00FF; fr[2] = 16'hFF00;
    fl[3] = 16'h5555; fr[3] = 16'hAAAA;
    fl[4] = 16'hC001; fr[4] = 16'h3FFE;

    i_rst_n = 1'b0; i_en = 1'b1; i_daclrck = 1'b1; i_mode = 1'b1;
    i_mono = 1'b0; i_valid = 1'b0; i_dac_l = '0; i_dac_r = '0;
    #1;
    chk("rst_dacdat", int'(o_aud_dacdat), 0);
    chk("rst_underrun", int'(o_underrun), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_ready", int'(o_ready), 1);
    step(); step();
    i_rst_n = 1'b1;
    step();

    // Left-justified frame
    push(16'hA5C3, 16'h0F0F, 1);
    slot(0, 20, 16'hA5C3, 0, 0, 0);
    slot(1, 20, 16'h0F0F, 0, -1, -1);

    // I2S frame
    push(16'hA5C3, 16'h0F0F, 1);
    slot(0, 20, 16'hA5C3, 1, 0, 0);
    slot(1, 20, 16'h0F0F, 1, -1, -1);

    // Mono duplication
    i_mono = 1'b1;
    push(16'h8001, 16'h7FFE, 1);
    slot(0, 20, 16'h8001, 0, 0, 0);
    slot(1, 20, 16'h8001, 0, -1, -1);
    i_mono = 1'b0;

    // Underrun on an empty FIFO, then three frames in order
    repeat (2) begin
      slot(0, 20, 16'h0000, 0, 1, 0);
      slot(1, 20, 16'h0000, 0, -1, -1);
    end
    for (int i = 0; i < 3; i++) push(fl[i], fr[i], i + 1);
    for (int i = 0; i < 3; i++) begin
      slot(0, 20, fl[i], 0, 0, 2 - i);
      slot(1, 20, fr[i], 0, -1, -1);
    end

    // Back-to-back pushes into a full FIFO
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_dac_l = fl[i];
      i_dac_r = fr[i];
      expect_at(cyc + 1, 2, (i < 4) ? i + 1 : 4);
      expect_at(cyc + 1, 3, (i < 3) ? 1 : 0);
      step();
    end
    i_valid = 1'b0;
    expect_at(cyc + 1, 3, 1);
    slot(0, 20, fl[0], 0, 0, 3);
    slot(1, 20, fr[0], 0, -1, -1);
    push(fl[4], fr[4], 4);
    for (int i = 1; i < 5; i++) begin
      slot(0, 20, fl[i], 0, 0, 4 - i);
      slot(1, 20, fr[i], 0, -1, -1);
    end

    // Short LRCK half-period truncates words without error
    push(16'hA5C3, 16'h0F0F, 1);
    slot(0, 10, 16'hA5C3, 0, 0, 0);
    slot(1, 10, 16'h0F0F, 0, -1, -1);
    push(16'h8001, 16'h7FFE, 1);
    slot(0, 10, 16'h8001, 1, 0, 0);
    slot(1, 10, 16'h7FFE, 1, -1, -1);

    // Reset mid-word with a frame still queued
    push(16'hA5C3, 16'h0F0F, 1);
    push(16'h1111, 16'h2222, 2);
    slot(0, 6, 16'hA5C3, 0, 0, 1);
    @(negedge i_bclk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_dacdat", int'(o_aud_dacdat), 0);
    chk("midrst_level", int'(o_level), 0);
    chk("midrst_ready", int'(o_ready), 1);
    step(); step();
    i_rst_n = 1'b1;
    step();
    slot(1, 20, 16'h0000, 0, -1, -1);
    push(16'h3C5A, 16'h9669, 1);
    slot(0, 20, 16'h3C5A, 0, 0, 0);
    slot(1, 20, 16'h9669, 0, -1, -1);

    for (int t = 0; t < 50 && exp_q.size() > 0; t++) step();
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
